// File: rtl/conv_mac_engine.sv
// Fixed-point convolution MAC: streams a TAPS-entry coefficient bank in, then
// multiply-accumulates TAPS-sample windows and emits one saturated result per window.
module conv_mac_engine #(
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 24,
  parameter int TAPS      = 9,
  parameter int GUARD_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_filter,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              relu_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              coef_ok
);

  localparam int ACC_W  = DATA_W + GUARD_W;
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  localparam int IDX_W  = (TAPS > 1) ? $clog2(TAPS) : 1;

  localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Handshake: a beat moves when in_valid && in_ready; a result moves when
  // out_valid && out_ready. out_valid/out_data hold until their handshake.
  typedef enum logic {ACCEPT, HOLD} state_t;

  state_t                    state_q, state_d;
  logic signed [DATA_W-1:0]  coef [TAPS];
  logic        [IDX_W-1:0]   idx_q;
  logic                      mode_q;
  logic signed [ACC_W-1:0]   acc_q;

  logic                      accept;
  logic                      mode_switch;
  logic        [IDX_W-1:0]   eidx;
  logic                      last_tap;
  logic signed [DATA_W-1:0]  sample;
  logic signed [PROD_W-1:0]  prod;
  logic signed [PROD_W-1:0]  shifted;
  logic signed [ACC_W-1:0]   acc_base;
  logic signed [SUM_W-1:0]   base_x;
  logic signed [SUM_W-1:0]   step_x;
  logic signed [SUM_W-1:0]   sum_x;
  logic signed [ACC_W-1:0]   acc_next;
  logic        [DATA_W-1:0]  sat_val;
  logic        [DATA_W-1:0]  result;

  // FSM: next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCEPT: begin
        in_ready = !reset;
        if (accept && !in_filter && last_tap) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = !reset && out_ready;
        if (out_ready) state_d = ACCEPT;
      end
      default: state_d = ACCEPT;
    endcase
  end

  // A beat whose mode differs from an open window restarts at index 0.
  always_comb begin
    accept      = in_valid && in_ready;
    mode_switch = (idx_q != '0) && (in_filter != mode_q);
    eidx        = mode_switch ? '0 : idx_q;
    last_tap    = (eidx == IDX_W'(TAPS - 1));
  end

  always_comb begin
    sample   = in_data;
    prod     = sample * coef[eidx];
    shifted  = prod >>> FRAC_BITS;
    acc_base = (eidx == '0) ? '0 : acc_q;
    base_x   = {{(SUM_W-ACC_W){acc_base[ACC_W-1]}}, acc_base};
    step_x   = {{(SUM_W-PROD_W){shifted[PROD_W-1]}}, shifted};
    sum_x    = base_x + step_x;
    if (sum_x > ACC_MAX)      acc_next = ACC_MAX[ACC_W-1:0];
    else if (sum_x < ACC_MIN) acc_next = ACC_MIN[ACC_W-1:0];
    else                      acc_next = sum_x[ACC_W-1:0];
    if (acc_next > OUT_MAX)      sat_val = OUT_MAX[DATA_W-1:0];
    else if (acc_next < OUT_MIN) sat_val = OUT_MIN[DATA_W-1:0];
    else                         sat_val = acc_next[DATA_W-1:0];
    result = (relu_en && sat_val[DATA_W-1]) ? '0 : sat_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ACCEPT;
      idx_q    <= '0;
      mode_q   <= 1'b0;
      acc_q    <= '0;
      out_data <= '0;
      coef_ok  <= 1'b0;
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q <= in_filter;
        idx_q  <= last_tap ? '0 : eidx + 1'b1;
        if (in_filter) begin
          coef[eidx] <= in_data;
          if (last_tap) coef_ok <= 1'b1;
        end else begin
          acc_q <= acc_next;
          if (last_tap) out_data <= result;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Self-checking bench for conv_mac_engine: directed scenarios plus randomized
// windows, compared against an arithmetic reference model and an expected queue.
module tb_conv_mac_engine;

  localparam int  TAPS = 9;
  localparam int  FRAC = 24;
  localparam longint ACC_MAX = (longint'(1) <<< 39) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< 39);
  localparam longint OUT_MAX = 64'sd2147483647;
  localparam longint OUT_MIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_filter;
  logic        in_valid;
  logic        in_ready;
  logic        relu_en;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        coef_ok;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] m_coef [TAPS];
  logic [31:0] coef_arr [TAPS];
  logic [31:0] smp_arr [TAPS];
  bit          m_coef_ok;
  bit          gap_en;

  conv_mac_engine #(.DATA_W(32), .FRAC_BITS(24), .TAPS(9), .GUARD_W(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_filter(in_filter),
    .in_valid(in_valid), .in_ready(in_ready), .relu_en(relu_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .coef_ok(coef_ok)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // reference model: plain Q8.24 arithmetic over the whole window
  function automatic logic [31:0] model_result(input bit relu);
    longint acc, p, s;
    acc = 0;
    for (int i = 0; i < TAPS; i++) begin
      p = longint'($signed(smp_arr[i])) * longint'($signed(m_coef[i]));
      s = p >>> FRAC;
      acc = acc + s;
      if (acc > ACC_MAX) acc = ACC_MAX;
      else if (acc < ACC_MIN) acc = ACC_MIN;
    end
    if (acc > OUT_MAX) acc = OUT_MAX;
    else if (acc < OUT_MIN) acc = OUT_MIN;
    if (relu && acc < 0) acc = 0;
    return acc[31:0];
  endfunction

  function automatic logic [31:0] rnd_val();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($urandom_range(0, 268435455)) - 32'd134217728;
  endfunction

  // driver tasks: all called aligned to a falling edge
  task automatic send_beat(input logic [31:0] d, input logic f);
    int guard;
    if (gap_en) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    in_data = d; in_filter = f; in_valid = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk); #1; guard++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL beat_accept: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_bank();
    for (int i = 0; i < TAPS; i++) begin
      if (i == TAPS - 1) begin
        checks++;
        if (coef_ok !== m_coef_ok) begin
          errors++;
          $display("FAIL coef_ok_before_last: got %0b required %0b", coef_ok, m_coef_ok);
        end
      end
      send_beat(coef_arr[i], 1'b1);
      m_coef[i] = coef_arr[i];
    end
    in_valid = 1'b0;
    m_coef_ok = 1'b1;
    checks++;
    if (coef_ok !== 1'b1) begin
      errors++;
      $display("FAIL coef_ok_after_load: got %0b required 1", coef_ok);
    end
  endtask

  task automatic send_samples(input int first, input int last_i);
    for (int i = first; i <= last_i; i++) begin
      if (i == TAPS - 1) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL early_valid: out_valid=%0b required 0 before last tap", out_valid);
        end
      end
      send_beat(smp_arr[i], 1'b0);
    end
    in_valid = 1'b0;
  endtask

  // scoreboard check, taken on the falling edge right after the last tap
  task automatic check_result(input string name, output logic [31:0] exp);
    exp = '0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid: out_valid=%0b required 1", name, out_valid);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_queue: no expected value queued", name);
    end else begin
      exp = exp_q.pop_front();
      if (out_data !== exp) begin
        errors++;
        $display("FAIL %s_data: out_data=%h required %h", name, out_data, exp);
      end
    end
  endtask

  task automatic run_window(input string name, input bit relu);
    logic [31:0] e;
    relu_en = relu;
    exp_q.push_back(model_result(relu));
    send_samples(0, TAPS - 1);
    check_result(name, e);
  endtask

  task automatic fill_const(input logic [31:0] c, input logic [31:0] s);
    for (int i = 0; i < TAPS; i++) begin coef_arr[i] = c; smp_arr[i] = s; end
  endtask

  task automatic fill_rand_samples();
    for (int i = 0; i < TAPS; i++) smp_arr[i] = rnd_val();
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %0b required 0", in_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_in_ready: got %0b required 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid);
    end
    checks++;
    if (out_data !== 32'h0) begin
      errors++; $display("FAIL reset_out_data: got %h required 0", out_data);
    end
    checks++;
    if (coef_ok !== 1'b0) begin
      errors++; $display("FAIL reset_coef_ok: got %0b required 0", coef_ok);
    end
    for (int i = 0; i < TAPS; i++) m_coef[i] = '0;
    m_coef_ok = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unity();
    fill_const(32'h0100_0000, 32'h0100_0000);
    load_bank();
    run_window("unity", 1'b0);
  endtask

  task automatic test_negative_relu();
    fill_const(32'hFF00_0000, 32'h0080_0000);
    load_bank();
    run_window("negative", 1'b0);
    run_window("relu", 1'b1);
  endtask

  task automatic test_saturation();
    fill_const(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    load_bank();
    run_window("sat_pos", 1'b0);
    fill_const(32'h8000_0000, 32'h7FFF_FFFF);
    load_bank();
    run_window("sat_neg", 1'b0);
  endtask

  task automatic test_backpressure();
    logic [31:0] hold_exp;
    logic [31:0] e;
    relu_en = 1'b0;
    for (int i = 0; i < TAPS; i++) coef_arr[i] = rnd_val();
    load_bank();
    fill_rand_samples();
    exp_q.push_back(model_result(1'b0));
    out_ready = 1'b0;
    send_samples(0, TAPS - 1);
    check_result("bp_first", hold_exp);
    fill_rand_samples();
    exp_q.push_back(model_result(1'b0));
    in_data = smp_arr[0]; in_filter = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== hold_exp) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d out_valid=%0b out_data=%h required 1/%h",
                 c, out_valid, out_data, hold_exp);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_in_ready: cycle %0d got %0b required 0", c, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %0b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drop_valid: got %0b required 0", out_valid);
    end
    send_samples(1, TAPS - 1);
    check_result("bp_second", e);
  endtask

  task automatic test_mode_switch();
    relu_en = 1'b0;
    for (int i = 0; i < TAPS; i++) coef_arr[i] = rnd_val();
    load_bank();
    fill_rand_samples();
    send_samples(0, 3);
    for (int i = 0; i < TAPS; i++) coef_arr[i] = rnd_val();
    load_bank();
    fill_rand_samples();
    run_window("switch_to_load", 1'b0);
    for (int i = 0; i < 3; i++) begin
      coef_arr[i] = rnd_val();
      send_beat(coef_arr[i], 1'b1);
      m_coef[i] = coef_arr[i];
    end
    in_valid = 1'b0;
    fill_rand_samples();
    run_window("switch_to_mac", 1'b0);
  endtask

  task automatic test_reset_mid_window();
    fill_const(32'h0100_0000, 32'h0100_0000);
    load_bank();
    send_samples(0, 4);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < TAPS; i++) m_coef[i] = '0;
    m_coef_ok = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_out_valid: got %0b required 0", out_valid);
    end
    checks++;
    if (coef_ok !== 1'b0) begin
      errors++; $display("FAIL midreset_coef_ok: got %0b required 0", coef_ok);
    end
    run_window("no_reload", 1'b0);
    checks++;
    if (coef_ok !== 1'b0) begin
      errors++; $display("FAIL no_reload_coef_ok: got %0b required 0", coef_ok);
    end
  endtask

  task automatic test_random();
    gap_en = 1'b1;
    for (int n = 0; n < 8; n++) begin
      if (n % 2 == 0) begin
        for (int i = 0; i < TAPS; i++) coef_arr[i] = rnd_val();
        load_bank();
      end
      fill_rand_samples();
      run_window("random", 1'($urandom_range(0, 1)));
    end
    gap_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_data = '0; in_filter = 1'b0; in_valid = 1'b0;
    relu_en = 1'b0; out_ready = 1'b1; gap_en = 1'b0; m_coef_ok = 1'b0;
    test_reset();
    test_unity();
    test_negative_relu();
    test_saturation();
    test_backpressure();
    test_mode_switch();
    test_reset_mid_window();
    test_random();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
